// File: rtl/qsfp_monitor_poller.sv
// qsfp_monitor_poller
//   Walks a fixed register list on every QSFP through the readout wrapper and
//   publishes one coherent snapshot per module. Each module costs six reads
//   (presence, status, temperature MSB/LSB, supply MSB/LSB). An absent module
//   costs only the presence read. All outputs of a module change together in
//   a single commit cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   hold            stalls the issue of new reads (an in-flight read completes)
//   scan_now        pulse: start a scan now if idle
//   readAddress     {qsfp index, register offset} to the readout wrapper
//   readData        byte from the readout wrapper, READ_LATENCY after address
//   present/valid   per-module presence and snapshot-valid flags
//   status          per-module status byte, 8 bits per module
//   temperature     per-module signed temperature, 1/256 degC, 16 bits per module
//   vsupply         per-module supply voltage, 100 uV LSB, 16 bits per module
//   temp_alarm      per-module level: temperature > TEMP_ALARM and valid
//   present_change  per-module one-cycle pulse when present toggles
//   scan_done       one-cycle pulse after the last module commits
//   scan_count      completed scans (wraps)
//   busy            scan in progress
module qsfp_monitor_poller #(
   parameter int                 QSFP_COUNT    = 2,
   parameter int                 READ_LATENCY  = 2,
   parameter int                 SCAN_INTERVAL = 1000000,
   parameter logic [7:0]         OFF_PRESENT   = 8'hFF,
   parameter logic [7:0]         OFF_STATUS    = 8'h02,
   parameter logic [7:0]         OFF_TEMP      = 8'h16,
   parameter logic [7:0]         OFF_VSUPPLY   = 8'h1A,
   parameter int                 PRESENT_BIT   = 0,
   parameter logic signed [15:0] TEMP_ALARM    = 16'sh4600
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              hold,
   input  logic                              scan_now,
   output logic [$clog2(QSFP_COUNT)+7:0]     readAddress,
   input  logic [7:0]                        readData,
   output logic [QSFP_COUNT-1:0]             present,
   output logic [QSFP_COUNT-1:0]             valid,
   output logic [8*QSFP_COUNT-1:0]           status,
   output logic [16*QSFP_COUNT-1:0]          temperature,
   output logic [16*QSFP_COUNT-1:0]          vsupply,
   output logic [QSFP_COUNT-1:0]             temp_alarm,
   output logic [QSFP_COUNT-1:0]             present_change,
   output logic                              scan_done,
   output logic [15:0]                       scan_count,
   output logic                              busy
);

   localparam int AW = $clog2(QSFP_COUNT) + 8;
   localparam int QW = (QSFP_COUNT > 1) ? $clog2(QSFP_COUNT) : 1;
   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [QW-1:0] Q_LAST   = QW'(QSFP_COUNT - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);
   localparam logic [31:0]   INT_LAST = 32'(SCAN_INTERVAL - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_COMMIT
   } state_t;

   typedef enum logic [2:0] {
      ST_PRESENT, ST_STATUS, ST_TMSB, ST_TLSB, ST_VMSB, ST_VLSB
   } step_t;

   state_t             state, state_d;
   step_t              step;
   logic [QW-1:0]      q;
   logic [LW-1:0]      lat_cnt;
   logic [31:0]        int_cnt;

   // Shadow registers: assembled here, copied to the outputs only at commit.
   logic               sh_present;
   logic [7:0]         sh_status;
   logic signed [15:0] sh_temp;
   logic [15:0]        sh_vs;

   logic               rst_s1, rst_s2;
   logic               rst_int_n;
   logic               absent_now;

   function automatic logic [7:0] offset_of(input step_t st);
      case (st)
         ST_PRESENT: return OFF_PRESENT;
         ST_STATUS:  return OFF_STATUS;
         ST_TMSB:    return OFF_TEMP;
         ST_TLSB:    return OFF_TEMP + 8'd1;
         ST_VMSB:    return OFF_VSUPPLY;
         default:    return OFF_VSUPPLY + 8'd1;
      endcase
   endfunction

   function automatic logic [AW-1:0] addr_of(input logic [QW-1:0] qi, input step_t st);
      return (AW'(qi) << 8) | AW'(offset_of(st));
   endfunction

   // Equality does not alarm.
   function automatic logic over_temp(input logic signed [15:0] t);
      return t > TEMP_ALARM;
   endfunction

   // Reset asserts asynchronously and is released on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_s1 <= 1'b0;
         rst_s2 <= 1'b0;
      end else begin
         rst_s1 <= 1'b1;
         rst_s2 <= rst_s1;
      end
   end

   assign rst_int_n  = rst_s2;
   assign absent_now = readData[PRESENT_BIT];
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) state <= S_IDLE;
      else            state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:    if (scan_now || int_cnt == INT_LAST) state_d = S_ISSUE;
         S_ISSUE:   if (!hold) state_d = S_WAIT;
         S_WAIT:    if (lat_cnt == LAT_LAST) state_d = S_CAPTURE;
         S_CAPTURE: begin
            if ((step == ST_PRESENT && absent_now) || step == ST_VLSB) state_d = S_COMMIT;
            else                                                       state_d = S_ISSUE;
         end
         S_COMMIT:  state_d = (q == Q_LAST) ? S_IDLE : S_ISSUE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         step           <= ST_PRESENT;
         q              <= '0;
         lat_cnt        <= '0;
         int_cnt        <= '0;
         readAddress    <= '0;
         present        <= '0;
         valid          <= '0;
         status         <= '0;
         temperature    <= '0;
         vsupply        <= '0;
         temp_alarm     <= '0;
         present_change <= '0;
         scan_done      <= 1'b0;
         scan_count     <= '0;
      end else begin
         present_change <= '0;
         scan_done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (scan_now || int_cnt == INT_LAST) begin
                  int_cnt <= '0;
                  q       <= '0;
                  step    <= ST_PRESENT;
               end else begin
                  int_cnt <= int_cnt + 32'd1;
               end
            end
            S_ISSUE: begin
               if (!hold) begin
                  readAddress <= addr_of(q, step);
                  lat_cnt     <= '0;
               end
            end
            S_WAIT: lat_cnt <= lat_cnt + 1'b1;
            S_CAPTURE: begin
               if (!(step == ST_PRESENT && absent_now) && step != ST_VLSB)
                  step <= step_t'(step + 3'd1);
            end
            S_COMMIT: begin
               present[q]               <= sh_present;
               valid[q]                 <= sh_present;
               status[8*q +: 8]         <= sh_status;
               temperature[16*q +: 16]  <= sh_temp;
               vsupply[16*q +: 16]      <= sh_vs;
               temp_alarm[q]            <= sh_present && over_temp(sh_temp);
               present_change[q]        <= present[q] ^ sh_present;
               step                     <= ST_PRESENT;
               q                        <= q + 1'b1;
               if (q == Q_LAST) begin
                  scan_done  <= 1'b1;
                  scan_count <= scan_count + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Shadow data carries no reset: a reset returns to IDLE and the next scan
   // rewrites every shadow field before it can be committed.
   always_ff @(posedge clk) begin
      if (state == S_CAPTURE) begin
         case (step)
            ST_PRESENT: begin
               sh_present <= ~absent_now;
               if (absent_now) begin
                  sh_status <= '0;
                  sh_temp   <= '0;
                  sh_vs     <= '0;
               end
            end
            ST_STATUS: sh_status     <= readData;
            ST_TMSB:   sh_temp[15:8] <= readData;
            ST_TLSB:   sh_temp[7:0]  <= readData;
            ST_VMSB:   sh_vs[15:8]   <= readData;
            default:   sh_vs[7:0]    <= readData;
         endcase
      end
   end

endmodule

// File: tb/tb_qsfp_monitor_poller.sv
// Testbench for qsfp_monitor_poller: a byte-addressable readout-wrapper model
// with READ_LATENCY delay, directed scans, and a scoreboard checked at every
// scan_done pulse.
module tb_qsfp_monitor_poller;

   localparam int QN = 2;
   localparam int RL = 2;
   localparam int SI = 3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hold = 1'b0;
   logic        scan_now = 1'b0;
   logic [8:0]  readAddress;
   logic [7:0]  readData;
   logic [1:0]  present, valid, temp_alarm, present_change;
   logic [15:0] status;
   logic [31:0] temperature, vsupply;
   logic        scan_done, busy;
   logic [15:0] scan_count;

   always #5 clk = ~clk;

   qsfp_monitor_poller #(
      .QSFP_COUNT(QN), .READ_LATENCY(RL), .SCAN_INTERVAL(SI)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .scan_now(scan_now),
      .readAddress(readAddress), .readData(readData),
      .present(present), .valid(valid), .status(status),
      .temperature(temperature), .vsupply(vsupply), .temp_alarm(temp_alarm),
      .present_change(present_change), .scan_done(scan_done),
      .scan_count(scan_count), .busy(busy)
   );

   // Readout wrapper model: data appears RL clocks after the address.
   logic [7:0] mem [QN][256];
   logic [8:0] a_d1 = '0, a_d2 = '0;
   always @(posedge clk) begin
      a_d1 <= readAddress;
      a_d2 <= a_d1;
   end
   assign readData = mem[a_d2[8]][a_d2[7:0]];

   task automatic set_mod(input int m, input logic [7:0] pres, input logic [7:0] st,
                          input logic [15:0] t, input logic [15:0] v);
      mem[m][8'hFF] = pres;
      mem[m][8'h02] = st;
      mem[m][8'h16] = t[15:8];
      mem[m][8'h17] = t[7:0];
      mem[m][8'h1A] = v[15:8];
      mem[m][8'h1B] = v[7:0];
   endtask

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  pres;
      logic [15:0] st;
      logic [31:0] t;
      logic [31:0] v;
      logic [1:0]  al;
      int          p0;
      int          p1;
      logic [15:0] cnt;
      int          bz;
      int          q1a;
   } exp_t;

   exp_t sb[$];
   exp_t cur;

   function automatic exp_t mk(input logic [1:0] pres, input logic [15:0] st,
                               input logic [31:0] t, input logic [31:0] v,
                               input logic [1:0] al, input int p0, input int p1,
                               input logic [15:0] cnt, input int bz, input int q1a);
      exp_t e;
      e.pres = pres; e.st = st; e.t = t; e.v = v; e.al = al;
      e.p0 = p0; e.p1 = p1; e.cnt = cnt; e.bz = bz; e.q1a = q1a;
      return e;
   endfunction

   // Monitor: accumulates pulses, busy cycles and QSFP1 address visits per
   // scan, watches temperature[15:0] for intermediate values, and compares a
   // snapshot against the scoreboard on every scan_done.
   int         pc0 = 0, pc1 = 0, bcnt = 0, q1a = 0;
   logic [8:0] prev_a = '0;
   logic [15:0] prev_t0 = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pc0 = 0; pc1 = 0; bcnt = 0; q1a = 0;
         prev_a  = readAddress;
         prev_t0 = temperature[15:0];
      end else begin
         pc0 += int'(present_change[0]);
         pc1 += int'(present_change[1]);
         if (busy) bcnt++;
         if (readAddress != prev_a && readAddress[8]) q1a++;
         prev_a = readAddress;
         if (temperature[15:0] != prev_t0) begin
            if (sb.size() == 0) chk("t0_unexpected_change", 64'(temperature[15:0]), 64'(prev_t0));
            else                chk("t0_no_torn_value", 64'(temperature[15:0]), 64'(sb[0].t[15:0]));
         end
         prev_t0 = temperature[15:0];
         if (scan_done) begin
            if (sb.size() == 0) begin
               chk("scan_done_unexpected", 64'(scan_done), 64'd0);
            end else begin
               cur = sb.pop_front();
               chk("present",        64'(present),     64'(cur.pres));
               chk("valid",          64'(valid),       64'(cur.pres));
               chk("status",         64'(status),      64'(cur.st));
               chk("temperature",    64'(temperature), 64'(cur.t));
               chk("vsupply",        64'(vsupply),     64'(cur.v));
               chk("temp_alarm",     64'(temp_alarm),  64'(cur.al));
               chk("present_change0_cycles", 64'(pc0), 64'(cur.p0));
               chk("present_change1_cycles", 64'(pc1), 64'(cur.p1));
               chk("scan_count",     64'(scan_count),  64'(cur.cnt));
               chk("busy_cycles",    64'(bcnt),        64'(cur.bz));
               chk("qsfp1_reads",    64'(q1a),         64'(cur.q1a));
            end
            pc0 = 0; pc1 = 0; bcnt = 0; q1a = 0;
         end
      end
   end

   task automatic pulse_scan();
      @(negedge clk);
      scan_now = 1'b1;
      @(negedge clk);
      scan_now = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (sb.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("scan_completed_in_time", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic wait_addr(input logic [8:0] a, input string nm);
      int n = 0;
      while (readAddress != a && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(readAddress), 64'(a));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_present"},     64'(present),        64'd0);
      chk({tag, "_valid"},       64'(valid),          64'd0);
      chk({tag, "_status"},      64'(status),         64'd0);
      chk({tag, "_temperature"}, 64'(temperature),    64'd0);
      chk({tag, "_vsupply"},     64'(vsupply),        64'd0);
      chk({tag, "_temp_alarm"},  64'(temp_alarm),     64'd0);
      chk({tag, "_pchange"},     64'(present_change), 64'd0);
      chk({tag, "_scan_done"},   64'(scan_done),      64'd0);
      chk({tag, "_scan_count"},  64'(scan_count),     64'd0);
      chk({tag, "_busy"},        64'(busy),           64'd0);
      chk({tag, "_readAddress"}, 64'(readAddress),    64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
      $fatal(1, "watchdog");
   end

   initial begin
      int moved;
      for (int m = 0; m < QN; m++)
         for (int a = 0; a < 256; a++)
            mem[m][a] = 8'h00;
      set_mod(0, 8'hFE, 8'h00, 16'h1980, 16'h80E8);
      set_mod(1, 8'h01, 8'hAA, 16'h7777, 16'h5555);

      repeat (4) @(negedge clk);
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Basic scan: QSFP0 present, QSFP1 absent (one read, 25+5 busy cycles).
      sb.push_back(mk(2'b01, 16'h0000, 32'h0000_1980, 32'h0000_80E8, 2'b00, 1, 0, 16'd1, 30, 1));
      pulse_scan();
      wait_done(200);

      // Threshold: equal does not alarm, one above does, negative does not.
      set_mod(0, 8'hFE, 8'h00, 16'h4600, 16'h80E8);
      sb.push_back(mk(2'b01, 16'h0000, 32'h0000_4600, 32'h0000_80E8, 2'b00, 0, 0, 16'd2, 30, 1));
      pulse_scan();
      wait_done(200);
      set_mod(0, 8'hFE, 8'h00, 16'h4601, 16'h80E8);
      sb.push_back(mk(2'b01, 16'h0000, 32'h0000_4601, 32'h0000_80E8, 2'b01, 0, 0, 16'd3, 30, 1));
      pulse_scan();
      wait_done(200);
      set_mod(0, 8'hFE, 8'h00, 16'hF000, 16'h80E8);
      sb.push_back(mk(2'b01, 16'h0000, 32'h0000_F000, 32'h0000_80E8, 2'b00, 0, 0, 16'd4, 30, 1));
      pulse_scan();
      wait_done(200);

      // hold raised in WAIT of the TEMP_MSB read for 50 cycles: that read
      // completes, the next issue stalls 47 extra cycles with the address frozen.
      set_mod(0, 8'hFE, 8'h5A, 16'h1980, 16'h80E8);
      sb.push_back(mk(2'b01, 16'h005A, 32'h0000_1980, 32'h0000_80E8, 2'b00, 0, 0, 16'd5, 77, 1));
      pulse_scan();
      wait_addr(9'h016, "reach_temp_msb_read");
      hold = 1'b1;
      moved = 0;
      repeat (50) begin
         @(negedge clk);
         if (readAddress != 9'h016) moved++;
      end
      hold = 1'b0;
      chk("hold_addr_frozen", 64'(moved), 64'd0);
      wait_done(300);

      // Model changes after TEMP_MSB was captured: MSB old (19), LSB new (55);
      // the output steps straight from 1980 to 1955 at commit.
      sb.push_back(mk(2'b01, 16'h005A, 32'h0000_1955, 32'h0000_80E8, 2'b00, 0, 0, 16'd6, 30, 1));
      pulse_scan();
      wait_addr(9'h017, "reach_temp_lsb_read");
      mem[0][8'h16] = 8'h2A;
      mem[0][8'h17] = 8'h55;
      wait_done(200);

      // Presence flips on both modules: one-cycle pulse on each.
      set_mod(0, 8'h01, 8'h5A, 16'h2A55, 16'h80E8);
      set_mod(1, 8'hFE, 8'h33, 16'h1234, 16'h1111);
      sb.push_back(mk(2'b10, 16'h3300, 32'h1234_0000, 32'h1111_0000, 2'b00, 1, 1, 16'd7, 30, 6));
      pulse_scan();
      wait_done(200);

      // scan_now while busy is ignored.
      sb.push_back(mk(2'b10, 16'h3300, 32'h1234_0000, 32'h1111_0000, 2'b00, 0, 0, 16'd8, 30, 6));
      pulse_scan();
      repeat (5) @(negedge clk);
      pulse_scan();
      repeat (5) @(negedge clk);
      pulse_scan();
      wait_done(200);
      repeat (40) @(negedge clk);
      chk("scan_now_busy_single_scan", 64'(scan_count), 64'd8);

      // Reset mid-scan clears everything asynchronously.
      pulse_scan();
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (SI - 20) @(negedge clk);
      chk("no_scan_before_interval_busy", 64'(bcnt), 64'd0);
      chk("no_scan_before_interval_count", 64'(scan_count), 64'd0);
      // The interval scan: QSFP1 rises from its reset value, QSFP0 stays absent.
      sb.push_back(mk(2'b10, 16'h3300, 32'h1234_0000, 32'h1111_0000, 2'b00, 0, 1, 16'd1, 30, 6));
      wait_done(300);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
